// File: rtl/jt12_opsched.sv
// Operator slot scheduler: 24-slot frame, per-channel {alg,fb} file, registered selects.
// Optional JT12_OPSCHED_CHMASK_EN adds ch_mask[5:0] to silence channels.
module jt12_opsched #(
    parameter int NUM_CH = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       wr,
    input  logic [2:0] wr_ch,
    input  logic [2:0] wr_alg,
    input  logic [2:0] wr_fb,
`ifdef JT12_OPSCHED_CHMASK_EN
    input  logic [5:0] ch_mask,
`endif
    output logic [4:0] slot,
    output logic       s1_enters,
    output logic       s3_enters,
    output logic       s2_enters,
    output logic       s4_enters,
    output logic       zero,
    output logic       use_prevprev1,
    output logic       use_internal_x,
    output logic       use_prev2,
    output logic       use_prev1,
    output logic       use_internal_y,
    output logic [2:0] fb_II
);

    logic [4:0] slot_q, slot_d;
    logic [2:0] ch_q, ch_d;
    logic [1:0] grp_q, grp_d;
    logic [3:0] strb_q, strb_d;
    logic       zero_q, zero_d;
    logic [4:0] use_q, use_d;
    logic [2:0] fbii_q, fbii_d;
    logic [2:0] alg_q [NUM_CH];
    logic [2:0] alg_d [NUM_CH];
    logic [2:0] fb_q [NUM_CH];
    logic [2:0] fb_d [NUM_CH];
    logic [2:0] nalg;
    logic [5:0] mask;

`ifdef JT12_OPSCHED_CHMASK_EN
    assign mask = ch_mask;
`else
    assign mask = 6'd0;
`endif

    // use vector bits: {prevprev1, internal_x, prev2, prev1, internal_y}
    always_comb begin
        slot_d = slot_q;
        ch_d   = ch_q;
        grp_d  = grp_q;
        strb_d = strb_q;
        zero_d = zero_q;
        use_d  = use_q;
        fbii_d = fbii_q;
        alg_d  = alg_q;
        fb_d   = fb_q;
        nalg   = 3'd0;
        if (clk_en) begin
            slot_d = (slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;
            if (ch_q == 3'd5) begin
                ch_d  = 3'd0;
                grp_d = grp_q + 2'd1;
            end else begin
                ch_d = ch_q + 3'd1;
            end
            nalg   = alg_q[ch_d];
            zero_d = (slot_d == 5'd0);
            strb_d = 4'b1000 >> grp_d;
            use_d  = 5'b00000;
            if (!mask[ch_d]) begin
                unique case (grp_d)
                    2'd0: use_d = 5'b10010;
                    2'd1: begin
                        case (nalg)
                            3'd0, 3'd3, 3'd4, 3'd5, 3'd6: use_d = 5'b00010;
                            default: use_d = 5'b00000;
                        endcase
                    end
                    2'd2: begin
                        case (nalg)
                            3'd0, 3'd2: use_d = 5'b00001;
                            3'd1:       use_d = 5'b00101;
                            3'd5:       use_d = 5'b00010;
                            default:    use_d = 5'b00000;
                        endcase
                    end
                    2'd3: begin
                        case (nalg)
                            3'd0, 3'd1, 3'd2, 3'd4: use_d = 5'b00001;
                            3'd3:    use_d = 5'b00101;
                            3'd5:    use_d = 5'b00010;
                            default: use_d = 5'b00000;
                        endcase
                    end
                endcase
            end
            // feedback follows the S1 slot that is being left
            fbii_d = (grp_q == 2'd0 && !mask[ch_q]) ? fb_q[ch_q] : 3'd0;
            if (wr && wr_ch < 3'(NUM_CH)) begin
                alg_d[wr_ch] = wr_alg;
                fb_d[wr_ch]  = wr_fb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= 5'd0;
            ch_q   <= 3'd0;
            grp_q  <= 2'd0;
            strb_q <= 4'b1000;
            zero_q <= 1'b1;
            use_q  <= 5'd0;
            fbii_q <= 3'd0;
            alg_q  <= '{default: 3'd0};
            fb_q   <= '{default: 3'd0};
        end else begin
            slot_q <= slot_d;
            ch_q   <= ch_d;
            grp_q  <= grp_d;
            strb_q <= strb_d;
            zero_q <= zero_d;
            use_q  <= use_d;
            fbii_q <= fbii_d;
            alg_q  <= alg_d;
            fb_q   <= fb_d;
        end
    end

    assign slot           = slot_q;
    assign s1_enters      = strb_q[3];
    assign s3_enters      = strb_q[2];
    assign s2_enters      = strb_q[1];
    assign s4_enters      = strb_q[0];
    assign zero           = zero_q;
    assign use_prevprev1  = use_q[4];
    assign use_internal_x = use_q[3];
    assign use_prev2      = use_q[2];
    assign use_prev1      = use_q[1];
    assign use_internal_y = use_q[0];
    assign fb_II          = fbii_q;

endmodule

// File: tb/tb_jt12_opsched.sv
// Bench for jt12_opsched: decode table, directed corner sequences, random vs reference model.
module tb_jt12_opsched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       wr = 1'b0;
    logic [2:0] wr_ch = 3'd0;
    logic [2:0] wr_alg = 3'd0;
    logic [2:0] wr_fb = 3'd0;
    logic [5:0] ch_mask = 6'd0;
    logic [4:0] slot;
    logic       s1_enters, s3_enters, s2_enters, s4_enters, zero;
    logic       use_prevprev1, use_internal_x, use_prev2, use_prev1, use_internal_y;
    logic [2:0] fb_II;

    int errors = 0;
    int checks = 0;

    jt12_opsched dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr(wr),
        .wr_ch(wr_ch), .wr_alg(wr_alg), .wr_fb(wr_fb),
`ifdef JT12_OPSCHED_CHMASK_EN
        .ch_mask(ch_mask),
`endif
        .slot(slot), .s1_enters(s1_enters), .s3_enters(s3_enters),
        .s2_enters(s2_enters), .s4_enters(s4_enters), .zero(zero),
        .use_prevprev1(use_prevprev1), .use_internal_x(use_internal_x),
        .use_prev2(use_prev2), .use_prev1(use_prev1),
        .use_internal_y(use_internal_y), .fb_II(fb_II)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // reference model: slot number and per-channel config as plain integers
    int       m_slot;
    int       m_alg [6];
    int       m_fb [6];
    int       m_fbii;
    bit [4:0] m_use;

    function automatic bit masked(input int ch);
`ifdef JT12_OPSCHED_CHMASK_EN
        return ch_mask[ch];
`else
        return 1'b0;
`endif
    endfunction

    // group 0=S1 1=S3 2=S2 3=S4; bits {pp1, ix, p2, p1, iy}
    function automatic bit [4:0] ref_use(input int g, input int alg);
        bit [4:0] r = 5'b0;
        case (g)
            0: r = 5'b10010;
            1: if (alg inside {0, 3, 4, 5, 6}) r = 5'b00010;
            2: begin
                if (alg inside {0, 2}) r = 5'b00001;
                if (alg == 1) r = 5'b00101;
                if (alg == 5) r = 5'b00010;
            end
            default: begin
                if (alg inside {0, 1, 2, 4}) r = 5'b00001;
                if (alg == 3) r = 5'b00101;
                if (alg == 5) r = 5'b00010;
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_slot = 0;
        m_fbii = 0;
        m_use  = 5'b0;
        for (int i = 0; i < 6; i++) begin
            m_alg[i] = 0;
            m_fb[i]  = 0;
        end
    endtask

    task automatic model_edge();
        int ch;
        ch = m_slot % 6;
        m_fbii = (m_slot / 6 == 0 && !masked(ch)) ? m_fb[ch] : 0;
        m_slot = (m_slot + 1) % 24;
        ch = m_slot % 6;
        m_use = masked(ch) ? 5'b0 : ref_use(m_slot / 6, m_alg[ch]);
        if (wr && wr_ch < 6) begin
            m_alg[wr_ch] = wr_alg;
            m_fb[wr_ch]  = wr_fb;
        end
    endtask

    task automatic check_all(input string name);
        bit [3:0]  e_strb;
        bit [12:0] act, exp;
        e_strb = 4'b1000 >> (m_slot / 6);
        exp = {5'(m_slot), e_strb, (m_slot == 0), 3'(m_fbii)};
        act = {slot, s1_enters, s3_enters, s2_enters, s4_enters, zero, fb_II};
        checks++;
        if (act !== exp || get_use() !== m_use) begin
            errors++;
            $display("FAIL %s: got slot=%0d strb=%b zero=%b use=%b fb_II=%0d, want slot=%0d strb=%b zero=%b use=%b fb_II=%0d",
                     name, slot, act[7:4], zero, get_use(), fb_II,
                     m_slot, e_strb, (m_slot == 0), m_use, m_fbii);
        end
    endtask

    function automatic bit [4:0] get_use();
        return {use_prevprev1, use_internal_x, use_prev2, use_prev1, use_internal_y};
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input string name, input bit en, input bit w,
                        input int c, input int a, input int f);
        @(negedge clk);
        clk_en = en;
        wr     = w;
        wr_ch  = 3'(c);
        wr_alg = 3'(a);
        wr_fb  = 3'(f);
        @(posedge clk);
        if (rst_n && en) model_edge();
        #1;
        check_all(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clk_en = 1'b0;
        wr = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int       grp;
        int       alg;
        bit [4:0] use_exp;
    } vec_t;

    localparam bit [4:0] ROWS [4][8] = '{
        '{5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b10010},
        '{5'b00010, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000},
        '{5'b00001, 5'b00101, 5'b00001, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000},
        '{5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00001, 5'b00010, 5'b00000, 5'b00000}
    };

    vec_t vt [32];

    initial begin
        int n;
        bit hit;
        for (int g = 0; g < 4; g++)
            for (int a = 0; a < 8; a++)
                vt[g * 8 + a] = '{g, a, ROWS[g][a]};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        do_reset();

        // two full frames, free running
        for (int i = 0; i < 48; i++) step("frame", 1'b1, 1'b0, 0, 0, 0);

        // decode table: every channel set to one algorithm, then a full frame
        for (int a = 0; a < 8; a++) begin
            for (int c = 0; c < 6; c++) step("tbl_wr", 1'b1, 1'b1, c, a, 7 - a);
            for (int i = 0; i < 24; i++) begin
                step("tbl_run", 1'b1, 1'b0, 0, 0, 0);
                n = (m_slot / 6) * 8 + a;
                checks++;
                if (get_use() !== vt[n].use_exp) begin
                    errors++;
                    $display("FAIL table g%0d a%0d: use=%b want %b",
                             vt[n].grp, vt[n].alg, get_use(), vt[n].use_exp);
                end
            end
        end

        // ch2 alg3 fb5: S4 slot 20 selects prev2+internal_y, fb_II=5 after slot 2
        do_reset();
        step("wr_ch2", 1'b1, 1'b1, 2, 3, 5);
        hit = 1'b0;
        for (int i = 0; i < 48 && !hit; i++) begin
            step("to20", 1'b1, 1'b0, 0, 0, 0);
            if (m_slot == 20) hit = 1'b1;
        end
        check_val("reach_slot20", int'(hit), 1);
        check_val("s20_prev2", int'(use_prev2), 1);
        check_val("s20_int_y", int'(use_internal_y), 1);
        hit = 1'b0;
        for (int i = 0; i < 48 && !hit; i++) begin
            step("to3", 1'b1, 1'b0, 0, 0, 0);
            if (m_slot == 3) hit = 1'b1;
        end
        check_val("reach_slot3", int'(hit), 1);
        check_val("fbII_after_s2", int'(fb_II), 5);

        // alternating enable: outputs hold on disabled cycles
        for (int i = 0; i < 20; i++) step("alt_en", 1'(i % 2 == 0), 1'b0, 0, 0, 0);

        // write ch1 alg7 while slot 1 is showing; slot 7 then has no select
        do_reset();
        step("to1", 1'b1, 1'b0, 0, 0, 0);
        check_val("at_slot1", int'(slot), 1);
        step("wr_ch1", 1'b1, 1'b1, 1, 7, 2);
        for (int i = 0; i < 5; i++) step("to7", 1'b1, 1'b0, 0, 0, 0);
        check_val("at_slot7", int'(slot), 7);
        check_val("s7_nosel", int'(get_use()), 0);

        // out-of-range channel write is ignored
        for (int c = 0; c < 6; c++) step("pre", 1'b1, 1'b1, c, c + 1, c);
        step("wr_ch6", 1'b1, 1'b1, 6, 0, 7);
        for (int i = 0; i < 24; i++) step("after_ch6", 1'b1, 1'b0, 0, 0, 0);

        // asynchronous reset mid-frame, then writes attempted during reset
        repeat (3) step("pre_rst", 1'b1, 1'b0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_wr", 1'b1, 1'b1, 0, 5, 6);
        step("rst_wr", 1'b1, 1'b1, 3, 5, 6);
        rst_n = 1'b1;
        step("first_en", 1'b1, 1'b0, 0, 0, 0);
        check_val("slot_after_rel", int'(slot), 1);
        for (int i = 0; i < 24; i++) step("post_rst", 1'b1, 1'b0, 0, 0, 0);

`ifdef JT12_OPSCHED_CHMASK_EN
        do_reset();
        ch_mask = 6'b000001;
        step("mwr", 1'b1, 1'b1, 0, 0, 7);
        for (int i = 0; i < 30; i++) begin
            step("mask_run", 1'b1, 1'b0, 0, 0, 0);
            if (m_slot % 6 == 0) check_val("mask_use", int'(get_use()), 0);
            if (m_slot == 1) check_val("mask_fb", int'(fb_II), 0);
        end
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
`ifdef JT12_OPSCHED_CHMASK_EN
            if (i % 97 == 0) ch_mask = 6'($urandom);
`endif
            step("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
